// File: rtl/esp32_ram_pkg.sv
// Shared constants and types for the ESP32 RAM arbiter slice.
package esp32_ram_pkg;

   localparam int ESP32_RAM_ADDR_W = 16;
   localparam int ESP32_RAM_DATA_W = 32;
   localparam int ESP32_RAM_BE_W   = ESP32_RAM_DATA_W / 8;
   localparam int ESP32_RAM_WORDS  = 51200;

   // Read-return tag travelling alongside the RAM read latency
   typedef struct packed {
      logic valid;
      logic master;
      logic oor;
   } ram_tag_t;

   // Command selected from the granted master
   typedef struct packed {
      logic [ESP32_RAM_ADDR_W-1:0] addr;
      logic [ESP32_RAM_BE_W-1:0]   be;
      logic [ESP32_RAM_DATA_W-1:0] wdata;
      logic                        write;
   } ram_cmd_t;

endpackage

// File: rtl/esp32_ram_arbiter_if.sv
// Avalon-MM master-side bundle for one requester of the shared RAM.
interface esp32_ram_arbiter_if;
   import esp32_ram_pkg::*;

   logic [ESP32_RAM_ADDR_W-1:0] address;
   logic [ESP32_RAM_BE_W-1:0]   byteenable;
   logic                        read;
   logic                        write;
   logic [ESP32_RAM_DATA_W-1:0] writedata;
   logic                        waitrequest;
   logic [ESP32_RAM_DATA_W-1:0] readdata;
   logic                        readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );

endinterface

// File: rtl/esp32_ram_arbiter_rr_arb2.sv
// Two-way round-robin grant with a bounded hold for the current owner.
module esp32_rr_arb2
   import esp32_ram_pkg::*;
#(
   parameter int BURST_LEN = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] grant,
   output logic       last_grant
);

   localparam logic [3:0] BURST = 4'(BURST_LEN);

   logic [3:0] hold_cnt;

   // Owner keeps the bus while under its hold budget, otherwise the other side wins
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11: begin
            if (hold_cnt < BURST) grant = last_grant ? 2'b10 : 2'b01;
            else                  grant = last_grant ? 2'b01 : 2'b10;
         end
         default: grant = 2'b00;
      endcase
   end

   // Track who was granted last and how many consecutive beats they have had
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_grant <= 1'b0;
         hold_cnt   <= 4'd0;
      end else if (grant == 2'b00) begin
         hold_cnt <= 4'd0;
      end else begin
         last_grant <= grant[1];
         if (grant[1] != last_grant)  hold_cnt <= 4'd1;
         else if (hold_cnt < BURST)   hold_cnt <= hold_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/esp32_ram_arbiter.sv
// Shares the single-port on-chip RAM between the Nios data master and the UART DMA.
module esp32_ram_arbiter
   import esp32_ram_pkg::*;
#(
   parameter int ADDR_W    = ESP32_RAM_ADDR_W,
   parameter int DATA_W    = ESP32_RAM_DATA_W,
   parameter int NUM_WORDS = ESP32_RAM_WORDS,
   parameter int BURST_LEN = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   esp32_ram_arbiter_if.slave    m0,
   esp32_ram_arbiter_if.slave    m1,
   output logic [ADDR_W-1:0]     ram_address,
   output logic [DATA_W/8-1:0]   ram_byteenable,
   output logic                  ram_chipselect,
   output logic                  ram_write,
   output logic [DATA_W-1:0]     ram_writedata,
   input  logic [DATA_W-1:0]     ram_readdata
);

   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_WORDS);

   logic [1:0] req;
   logic [1:0] grant;
   logic       last_grant;
   logic       accept;
   logic       oor;
   ram_cmd_t   cmd;
   logic       rd_valid_q1;
   logic       rd_oor_q1;
   ram_tag_t   tag_s1;
   ram_tag_t   tag_s2;

   assign req = {m1.read | m1.write, m0.read | m0.write};

   esp32_rr_arb2 #(.BURST_LEN(BURST_LEN)) u_arb (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .grant      (grant),
      .last_grant (last_grant)
   );

   assign m0.waitrequest = reset | ~grant[0];
   assign m1.waitrequest = reset | ~grant[1];
   assign accept         = ~reset & (grant != 2'b00);

   // Pick the granted master's command; write wins when read and write are both set
   always_comb begin
      cmd = '0;
      if (grant[1]) begin
         cmd.addr  = m1.address;
         cmd.be    = m1.byteenable;
         cmd.wdata = m1.writedata;
         cmd.write = m1.write;
      end else begin
         cmd.addr  = m0.address;
         cmd.be    = m0.byteenable;
         cmd.wdata = m0.writedata;
         cmd.write = m0.write;
      end
   end

   assign oor = ({1'b0, cmd.addr} >= LIMIT);

   // Register the accepted command onto the RAM port; out-of-range never selects the RAM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_address    <= '0;
         ram_byteenable <= '0;
         ram_writedata  <= '0;
         ram_chipselect <= 1'b0;
         ram_write      <= 1'b0;
      end else if (accept) begin
         ram_address    <= cmd.addr;
         ram_byteenable <= cmd.be;
         ram_writedata  <= cmd.wdata;
         ram_chipselect <= ~oor;
         ram_write      <= cmd.write & ~oor;
      end else begin
         ram_chipselect <= 1'b0;
         ram_write      <= 1'b0;
      end
   end

   // After an accept, last_grant already names the issuing master, so stage 1 borrows it
   assign tag_s1 = '{valid: rd_valid_q1, master: last_grant, oor: rd_oor_q1};

   // Two-stage read tag pipeline matching the RAM's address-to-q latency
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_valid_q1 <= 1'b0;
         rd_oor_q1   <= 1'b0;
         tag_s2      <= '0;
      end else begin
         rd_valid_q1 <= accept & ~cmd.write;
         rd_oor_q1   <= oor;
         tag_s2      <= tag_s1;
      end
   end

   assign m0.readdatavalid = tag_s2.valid & ~tag_s2.master;
   assign m1.readdatavalid = tag_s2.valid &  tag_s2.master;
   assign m0.readdata      = (m0.readdatavalid & ~tag_s2.oor) ? ram_readdata : '0;
   assign m1.readdata      = (m1.readdatavalid & ~tag_s2.oor) ? ram_readdata : '0;

endmodule

// File: tb/tb_esp32_ram_arbiter.sv
// Directed self-checking bench for the two-master RAM arbiter.
module tb_esp32_ram_arbiter;
   import esp32_ram_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect;
   logic        ram_write;
   logic [31:0] ram_writedata;
   logic [31:0] ram_readdata;

   int checks;
   int failures;

   esp32_ram_arbiter_if m0_bus();
   esp32_ram_arbiter_if m1_bus();

   esp32_ram_arbiter #(
      .ADDR_W    (16),
      .DATA_W    (32),
      .NUM_WORDS (51200),
      .BURST_LEN (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .m0             (m0_bus),
      .m1             (m1_bus),
      .ram_address    (ram_address),
      .ram_byteenable (ram_byteenable),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_writedata  (ram_writedata),
      .ram_readdata   (ram_readdata)
   );

   always #5 clk = ~clk;

   // RAM model: 51200 words, registered q, byte-lane writes; inputs latched mid-cycle
   logic [31:0] mem [0:51199];
   initial begin
      logic [15:0] a_l;
      logic [3:0]  be_l;
      logic        cs_l, we_l;
      logic [31:0] wd_l, w;
      for (int i = 0; i < 51200; i++) mem[i] = {16'hA5A5, 16'(i)};
      ram_readdata = '0;
      forever begin
         @(negedge clk);
         a_l  = ram_address;
         be_l = ram_byteenable;
         cs_l = ram_chipselect;
         we_l = ram_write;
         wd_l = ram_writedata;
         @(posedge clk);
         if (cs_l) begin
            ram_readdata = mem[a_l];
            if (we_l) begin
               w = mem[a_l];
               for (int b = 0; b < 4; b++)
                  if (be_l[b]) w[8*b +: 8] = wd_l[8*b +: 8];
               mem[a_l] = w;
            end
         end
      end
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [1:0] rd, input logic [1:0] wr,
                                 input logic [15:0] a0, input logic [3:0] be0, input logic [31:0] d0,
                                 input logic [15:0] a1, input logic [3:0] be1, input logic [31:0] d1);
      m0_bus.read       = rd[0];
      m0_bus.write      = wr[0];
      m0_bus.address    = a0;
      m0_bus.byteenable = be0;
      m0_bus.writedata  = d0;
      m1_bus.read       = rd[1];
      m1_bus.write      = wr[1];
      m1_bus.address    = a1;
      m1_bus.byteenable = be1;
      m1_bus.writedata  = d1;
      @(negedge clk);
   endtask

   task automatic apply_idle();
      apply_stimulus(2'b00, 2'b00, 16'h0, 4'h0, 32'h0, 16'h0, 4'h0, 32'h0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic        exp_m [0:11];
      logic [15:0] exp_a [0:11];
      logic        exp;
      int          n0, n1;
      checks   = 0;
      failures = 0;
      reset    = 1'b1;

      // Reset: a request is refused and everything is quiet
      apply_stimulus(2'b01, 2'b00, 16'h0010, 4'hF, 32'h0, 16'h0, 4'h0, 32'h0);
      check_output("rst_m0_wait", 32'(m0_bus.waitrequest), 32'd1);
      check_output("rst_m1_wait", 32'(m1_bus.waitrequest), 32'd1);
      check_output("rst_cs", 32'(ram_chipselect), 32'd0);
      check_output("rst_addr", 32'(ram_address), 32'd0);
      check_output("rst_m0_rdv", 32'(m0_bus.readdatavalid), 32'd0);
      next_cycle();
      next_cycle();
      reset = 1'b0;

      // Release with no requests
      apply_idle();
      check_output("rel_cs", 32'(ram_chipselect), 32'd0);
      check_output("rel_m0_wait", 32'(m0_bus.waitrequest), 32'd1);
      check_output("rel_m1_wait", 32'(m1_bus.waitrequest), 32'd1);
      check_output("rel_m0_rdv", 32'(m0_bus.readdatavalid), 32'd0);
      check_output("rel_m1_rdv", 32'(m1_bus.readdatavalid), 32'd0);
      check_output("rel_m0_rdata", m0_bus.readdata, 32'd0);
      next_cycle();

      // m0 write then read back
      apply_stimulus(2'b00, 2'b01, 16'h0010, 4'hF, 32'hDEADBEEF, 16'h0, 4'h0, 32'h0);
      check_output("t2_wr_wait", 32'(m0_bus.waitrequest), 32'd0);
      next_cycle();
      apply_stimulus(2'b01, 2'b00, 16'h0010, 4'hF, 32'h0, 16'h0, 4'h0, 32'h0);
      check_output("t2_ram_write", 32'(ram_write), 32'd1);
      check_output("t2_ram_cs", 32'(ram_chipselect), 32'd1);
      check_output("t2_ram_addr", 32'(ram_address), 32'h10);
      check_output("t2_ram_wdata", ram_writedata, 32'hDEADBEEF);
      check_output("t2_rd_wait", 32'(m0_bus.waitrequest), 32'd0);
      next_cycle();
      apply_idle();
      check_output("t2_rdv_t1", 32'(m0_bus.readdatavalid), 32'd0);
      check_output("t2_ram_write_rd", 32'(ram_write), 32'd0);
      next_cycle();
      apply_idle();
      check_output("t2_rdv_t2", 32'(m0_bus.readdatavalid), 32'd1);
      check_output("t2_rdata", m0_bus.readdata, 32'hDEADBEEF);
      check_output("t2_m1_rdv", 32'(m1_bus.readdatavalid), 32'd0);
      check_output("t2_m1_rdata", m1_bus.readdata, 32'd0);
      next_cycle();
      apply_idle();
      check_output("t2_rdv_t3", 32'(m0_bus.readdatavalid), 32'd0);
      next_cycle();

      // Both masters stream reads: m0 x4, m1 x4, m0 x4 with steered returns
      n0 = 0;
      n1 = 0;
      for (int cyc = 0; cyc < 14; cyc++) begin
         exp = 1'b0;
         if (cyc < 12) begin
            apply_stimulus(2'b11, 2'b00, 16'h0100 + 16'(n0), 4'hF, 32'h0,
                           16'h0200 + 16'(n1), 4'hF, 32'h0);
            exp        = (cyc >= 4 && cyc < 8);
            exp_m[cyc] = exp;
            exp_a[cyc] = exp ? 16'h0200 + 16'(n1) : 16'h0100 + 16'(n0);
            check_output($sformatf("t3_m0_wait_c%0d", cyc), 32'(m0_bus.waitrequest), 32'(exp));
            check_output($sformatf("t3_m1_wait_c%0d", cyc), 32'(m1_bus.waitrequest), 32'(!exp));
         end else begin
            apply_idle();
         end
         if (cyc >= 2) begin
            check_output($sformatf("t3_m0_rdv_c%0d", cyc), 32'(m0_bus.readdatavalid), 32'(!exp_m[cyc-2]));
            check_output($sformatf("t3_m1_rdv_c%0d", cyc), 32'(m1_bus.readdatavalid), 32'(exp_m[cyc-2]));
            if (exp_m[cyc-2])
               check_output($sformatf("t3_m1_rdata_c%0d", cyc), m1_bus.readdata, {16'hA5A5, exp_a[cyc-2]});
            else
               check_output($sformatf("t3_m0_rdata_c%0d", cyc), m0_bus.readdata, {16'hA5A5, exp_a[cyc-2]});
         end else begin
            check_output($sformatf("t3_m0_rdv_c%0d", cyc), 32'(m0_bus.readdatavalid), 32'd0);
            check_output($sformatf("t3_m1_rdv_c%0d", cyc), 32'(m1_bus.readdatavalid), 32'd0);
         end
         next_cycle();
         if (cyc < 12) begin
            if (exp) n1++;
            else     n0++;
         end
      end

      // Range boundary: last word in range, first word and top address out of range
      apply_stimulus(2'b01, 2'b00, 16'hC7FF, 4'hF, 32'h0, 16'h0, 4'h0, 32'h0);
      check_output("t4_m0_wait", 32'(m0_bus.waitrequest), 32'd0);
      next_cycle();
      apply_stimulus(2'b10, 2'b00, 16'h0, 4'h0, 32'h0, 16'hC800, 4'hF, 32'h0);
      check_output("t4_inrange_cs", 32'(ram_chipselect), 32'd1);
      check_output("t4_inrange_addr", 32'(ram_address), 32'hC7FF);
      check_output("t4_m1_rd_wait", 32'(m1_bus.waitrequest), 32'd0);
      next_cycle();
      apply_stimulus(2'b00, 2'b10, 16'h0, 4'h0, 32'h0, 16'hFFFF, 4'hF, 32'h12345678);
      check_output("t4_oor_rd_cs", 32'(ram_chipselect), 32'd0);
      check_output("t4_m1_wr_wait", 32'(m1_bus.waitrequest), 32'd0);
      check_output("t4_m0_rdv", 32'(m0_bus.readdatavalid), 32'd1);
      check_output("t4_m0_rdata", m0_bus.readdata, 32'hA5A5C7FF);
      next_cycle();
      apply_idle();
      check_output("t4_oor_wr_cs", 32'(ram_chipselect), 32'd0);
      check_output("t4_oor_wr_we", 32'(ram_write), 32'd0);
      check_output("t4_m1_rdv", 32'(m1_bus.readdatavalid), 32'd1);
      check_output("t4_m1_rdata", m1_bus.readdata, 32'd0);
      check_output("t4_m0_rdv_off", 32'(m0_bus.readdatavalid), 32'd0);
      next_cycle();
      apply_idle();
      check_output("t4_wr_no_rdv", 32'(m1_bus.readdatavalid), 32'd0);
      next_cycle();

      // Byte-lane write merges into existing word
      apply_stimulus(2'b00, 2'b01, 16'h0020, 4'hF, 32'h11223344, 16'h0, 4'h0, 32'h0);
      next_cycle();
      apply_stimulus(2'b00, 2'b01, 16'h0020, 4'b0010, 32'h0000AB00, 16'h0, 4'h0, 32'h0);
      check_output("t5_wdata_full", ram_writedata, 32'h11223344);
      next_cycle();
      apply_stimulus(2'b01, 2'b00, 16'h0020, 4'hF, 32'h0, 16'h0, 4'h0, 32'h0);
      check_output("t5_be", 32'(ram_byteenable), 32'h2);
      next_cycle();
      apply_idle();
      next_cycle();
      apply_idle();
      check_output("t5_rdv", 32'(m0_bus.readdatavalid), 32'd1);
      check_output("t5_rdata", m0_bus.readdata, 32'h1122AB44);
      next_cycle();

      // Reset while a read is in flight drops it; m0 leads afterwards
      apply_stimulus(2'b01, 2'b00, 16'h0010, 4'hF, 32'h0, 16'h0, 4'h0, 32'h0);
      check_output("t6_m0_wait", 32'(m0_bus.waitrequest), 32'd0);
      next_cycle();
      reset = 1'b1;
      apply_idle();
      check_output("t6_rst_cs", 32'(ram_chipselect), 32'd0);
      check_output("t6_rst_rdv", 32'(m0_bus.readdatavalid), 32'd0);
      next_cycle();
      reset = 1'b0;
      apply_idle();
      check_output("t6_t2_rdv", 32'(m0_bus.readdatavalid), 32'd0);
      check_output("t6_t2_rdata", m0_bus.readdata, 32'd0);
      next_cycle();
      for (int k = 0; k < 5; k++) begin
         apply_stimulus(2'b11, 2'b00, 16'h0, 4'hF, 32'h0, 16'h0, 4'hF, 32'h0);
         check_output($sformatf("t6_m0_wait_k%0d", k), 32'(m0_bus.waitrequest), 32'(k == 4));
         check_output($sformatf("t6_m1_wait_k%0d", k), 32'(m1_bus.waitrequest), 32'(k != 4));
         next_cycle();
      end
      apply_idle();
      next_cycle();
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
